regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-write, dual-read CPU register file.
- Adds configurable width, depth and read-port count, plus a second write port for dual-issue/load-return writeback.
- Adds synchronous clear and a per-register busy scoreboard for pipeline hazard detection.
- Sits between decode (read/reserve) and writeback (write) in the CPU datapath.

Parameters:
- DW, 32, data width of each register.
- NREG, 32, number of architectural registers (2..2^AW); register 0 hardwired to zero.
- AW, 5, register address width.
- NRD, 2, number of independent read ports (1..8).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous active-high reset.
- Rn  in  NRD*AW  read addresses; port i at [i*AW +: AW].
- Rd  out  NRD*DW  read data; port i at [i*DW +: DW].
- Busy  out  NRD  scoreboard busy bit for each read address.
- Write0  in  1  write enable, port 0.
- Wn0  in  AW  write address, port 0.
- Wd0  in  DW  write data, port 0.
- Write1  in  1  write enable, port 1.
- Wn1  in  AW  write address, port 1.
- Wd1  in  DW  write data, port 1.
- Rsv  in  1  reserve enable; marks RsvN pending.
- RsvN  in  AW  register to reserve.

Behaviour:
- Clock is the single clock.
- Reset is synchronous and active-high, sampled on the Clock rising edge. It clears all registers to 0 and all busy bits to 0. Writes and reserves in a reset cycle are ignored.
- Reset mid-operation takes effect at that edge: any in-flight reservation is dropped.
- Reads are combinational (zero-cycle latency) from Rn to Rd and Busy. After reset, every Rd reads 0 and every Busy reads 0.
- Writes commit on the rising edge when the enable is 1. New data is visible on Rd the following cycle (without bypass, see Optional Feature).
- Register 0:
  - Always reads 0.
  - Writes to it are discarded.
  - It is never busy; reserving it is a no-op.
- Addresses >= NREG: read 0 with Busy 0; writes and reserves to them are discarded.
- Write0 and Write1 to the same register in one cycle: port 1 wins and Wd1 is stored. Different registers are written independently.
- Scoreboard:
  - busy[r] is set at the edge where Rsv=1 and RsvN=r.
  - busy[r] is cleared at the edge where either write port writes r.
  - Reserve and write to the same r in one cycle: busy ends set, because the reserve is a newer producer. The data is still written.
  - Reserving an already-busy register keeps it busy; there is no counting.
- Busy[i] = busy[Rn_i] as registered state (modified by bypass, see below).
- All read ports are identical and independent. Any number may address the same register.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose address matches an active write port in the same cycle returns that port's write data combinationally. Port 1 takes priority over port 0 on a double match.
  - Busy for that read reports 0, unless Rsv targets the same register that cycle.
  - Register 0 and out-of-range addresses are never bypassed.
- Undefined: reads return the stored value, with new data one cycle after the write edge. Busy reflects registered state only.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then assert Reset for one cycle -> Rd for r5 reads 0 and Busy 0 on the next cycle.
- Single and dual write: Write0 r1=32 and Write1 r2=32 in one cycle, then Rn={r2,r1} -> both Rd read 32; Rn=r0 -> 0.
- Write collision: Write0 r7=0x11 and Write1 r7=0x22 in the same cycle -> r7 reads 0x22. Write0 r0=0x55 -> r0 still reads 0.
- Scoreboard:
  - Rsv r3 -> Busy=1 next cycle.
  - Write0 r3=9 -> Busy=0 next cycle, Rd=9.
  - Rsv r3 with Write1 r3=4 in the same cycle -> Busy=1, Rd=4.
- Bypass with REGFILE_BYPASS_EN: Write0 r4=0xA5, Rn0=r4 in the same cycle -> Rd0=0xA5 in that cycle. Without the macro -> old value in that cycle, 0xA5 next cycle.
- Parameter sweep: NREG=16, NRD=4, DW=16 -> a write to r15 is readable on all 4 ports; a write to r20 is discarded and reads 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NRD combinational read ports, two write ports,
// per-register busy scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_mp #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NRD*AW-1:0] Rn,
    output logic [NRD*DW-1:0] Rd,
    output logic [NRD-1:0]    Busy,
    input  logic              Write0,
    input  logic [AW-1:0]     Wn0,
    input  logic [DW-1:0]     Wd0,
    input  logic              Write1,
    input  logic [AW-1:0]     Wn1,
    input  logic [DW-1:0]     Wd1,
    input  logic              Rsv,
    input  logic [AW-1:0]     RsvN
);

    // Register 0 has no storage; addresses >= NREG never match any decoder output.
    logic [DW-1:0]   regs [1:NREG-1];
    logic [NREG-1:1] busy;
    logic [NREG-1:1] hit0;
    logic [NREG-1:1] hit1;
    logic [NREG-1:1] hit_rsv;

    always_comb begin
        hit0    = '0;
        hit1    = '0;
        hit_rsv = '0;
        for (int r = 1; r < NREG; r++) begin
            hit0[r]    = Write0 && (Wn0 == AW'(r));
            hit1[r]    = Write1 && (Wn1 == AW'(r));
            hit_rsv[r] = Rsv && (RsvN == AW'(r));
        end
    end

    // Port 1 wins a same-register collision; a reserve outranks a write for the busy bit
    // because it names a newer producer.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int r = 1; r < NREG; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (hit1[r]) begin
                    regs[r] <= Wd1;
                end else if (hit0[r]) begin
                    regs[r] <= Wd0;
                end
                if (hit_rsv[r]) begin
                    busy[r] <= 1'b1;
                end else if (hit0[r] || hit1[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        Rd   = '0;
        Busy = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int r = 1; r < NREG; r++) begin
                if (Rn[i*AW +: AW] == AW'(r)) begin
                    Rd[i*DW +: DW] = regs[r];
                    Busy[i]        = busy[r];
`ifdef REGFILE_BYPASS_EN
                    // Writes in a reset cycle are not committed, so they are not forwarded either.
                    if (!Reset && (hit0[r] || hit1[r])) begin
                        Rd[i*DW +: DW] = hit1[r] ? Wd1 : Wd0;
                        Busy[i]        = hit_rsv[r];
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance and a DW=16/NREG=16/NRD=4 instance driven in
// lockstep, checked against an array model, a vector table and hand-written sequences.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // clock / reset and shared stimulus
    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        write0, write1, rsv;
    logic [4:0]  wn0, wn1, rsvn;
    logic [31:0] wd0, wd1;
    logic [9:0]  rn;
    logic [63:0] rd;
    logic [1:0]  busy;
    logic [19:0] rn_s;
    logic [63:0] rd_s;
    logic [3:0]  busy_s;

    regfile_mp dut (
        .Clock(clock), .Reset(reset), .Rn(rn), .Rd(rd), .Busy(busy),
        .Write0(write0), .Wn0(wn0), .Wd0(wd0),
        .Write1(write1), .Wn1(wn1), .Wd1(wd1),
        .Rsv(rsv), .RsvN(rsvn)
    );

    regfile_mp #(.DW(16), .NREG(16), .AW(5), .NRD(4)) dut_s (
        .Clock(clock), .Reset(reset), .Rn(rn_s), .Rd(rd_s), .Busy(busy_s),
        .Write0(write0), .Wn0(wn0), .Wd0(wd0[15:0]),
        .Write1(write1), .Wn1(wn1), .Wd1(wd1[15:0]),
        .Rsv(rsv), .RsvN(rsvn)
    );

    // reference model: plain arrays, index 0 = default instance, 1 = sweep instance
    logic [31:0] m_mem [2][32];
    bit          m_bsy [2][32];
    int          m_nreg [2] = '{32, 16};
    logic [31:0] m_mask [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};

    // scoreboard
    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    function automatic bit in_range(int k, logic [4:0] a);
        return (a != 5'd0) && (int'(a) < m_nreg[k]);
    endfunction

    function automatic void model_read(input int k, input logic [4:0] a,
                                       output logic [31:0] d, output bit b);
        d = 32'd0;
        b = 1'b0;
        if (in_range(k, a)) begin
            d = m_mem[k][a];
            b = m_bsy[k][a];
            if (BYP && !reset) begin
                if (write1 && wn1 == a) begin
                    d = wd1 & m_mask[k];
                    b = rsv && (rsvn == a);
                end else if (write0 && wn0 == a) begin
                    d = wd0 & m_mask[k];
                    b = rsv && (rsvn == a);
                end
            end
        end
    endfunction

    function automatic void model_step(int k);
        if (reset) begin
            for (int a = 0; a < 32; a++) begin
                m_mem[k][a] = 32'd0;
                m_bsy[k][a] = 1'b0;
            end
        end else begin
            if (write0 && in_range(k, wn0)) begin
                m_mem[k][wn0] = wd0 & m_mask[k];
                m_bsy[k][wn0] = 1'b0;
            end
            if (write1 && in_range(k, wn1)) begin
                m_mem[k][wn1] = wd1 & m_mask[k];
                m_bsy[k][wn1] = 1'b0;
            end
            if (rsv && in_range(k, rsvn)) m_bsy[k][rsvn] = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] d;
        bit b;
        for (int i = 0; i < 2; i++) begin
            model_read(0, rn[i*5 +: 5], d, b);
            exp_q.push_back(d);
            exp_q.push_back(32'(b));
        end
        for (int i = 0; i < 4; i++) begin
            model_read(1, rn_s[i*5 +: 5], d, b);
            exp_q.push_back(d);
            exp_q.push_back(32'(b));
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_rd%0d_a%0d", i, rn[i*5 +: 5]), rd[i*32 +: 32], exp_q.pop_front());
            chk($sformatf("model_busy%0d_a%0d", i, rn[i*5 +: 5]), 32'(busy[i]), exp_q.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sweep_rd%0d_a%0d", i, rn_s[i*5 +: 5]), 32'(rd_s[i*16 +: 16]), exp_q.pop_front());
            chk($sformatf("sweep_busy%0d_a%0d", i, rn_s[i*5 +: 5]), 32'(busy_s[i]), exp_q.pop_front());
        end
    endtask

    // driver tasks
    task automatic idle();
        reset  = 1'b0;
        write0 = 1'b0; wn0 = 5'd0; wd0 = 32'd0;
        write1 = 1'b0; wn1 = 5'd0; wd1 = 32'd0;
        rsv    = 1'b0; rsvn = 5'd0;
    endtask

    task automatic tick_model();
        @(posedge clock);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic step();
        @(negedge clock);
        check_model();
        tick_model();
    endtask

    function automatic logic [4:0] pick();
        case ($urandom_range(0, 3))
            0:       return wn0;
            1:       return wn1;
            2:       return rsvn;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    typedef struct {
        bit          w0;
        logic [4:0]  n0;
        logic [31:0] d0;
        bit          w1;
        logic [4:0]  n1;
        logic [31:0] d1;
        bit          rs;
        logic [4:0]  rsn;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
        bit          b0;
        bit          b1;
    } vec_t;

    function automatic vec_t mk(bit w0, logic [4:0] n0, logic [31:0] d0,
                                bit w1, logic [4:0] n1, logic [31:0] d1,
                                bit rs, logic [4:0] rsn, logic [4:0] a0, logic [4:0] a1,
                                logic [31:0] e0, logic [31:0] e1, bit b0, bit b1);
        vec_t v;
        v.w0 = w0; v.n0 = n0; v.d0 = d0;
        v.w1 = w1; v.n1 = n1; v.d1 = d1;
        v.rs = rs; v.rsn = rsn; v.a0 = a0; v.a1 = a1;
        v.e0 = e0; v.e1 = e1; v.b0 = b0; v.b1 = b1;
        return v;
    endfunction

    localparam int NV = 12;
    vec_t tbl [NV];

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Each row: one cycle of writes/reserves, then an idle cycle reading a0/a1.
        tbl[0]  = mk(1'b1, 5'd1,  32'd32,        1'b1, 5'd2,  32'd32,        1'b0, 5'd0, 5'd2,  5'd1,  32'd32,        32'd32,        1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  32'd0,         1'b0, 5'd0, 5'd0,  5'd1,  32'd0,         32'd32,        1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 5'd7,  32'h11,        1'b1, 5'd7,  32'h22,        1'b0, 5'd0, 5'd7,  5'd0,  32'h22,        32'd0,         1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 5'd0,  32'h55,        1'b0, 5'd0,  32'd0,         1'b0, 5'd0, 5'd0,  5'd7,  32'd0,         32'h22,        1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  32'd0,         1'b1, 5'd3, 5'd3,  5'd1,  32'd0,         32'd32,        1'b1, 1'b0);
        tbl[5]  = mk(1'b1, 5'd3,  32'd9,         1'b0, 5'd0,  32'd0,         1'b0, 5'd0, 5'd3,  5'd3,  32'd9,         32'd9,         1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 5'd0,  32'd0,         1'b1, 5'd3,  32'd4,         1'b1, 5'd3, 5'd3,  5'd2,  32'd4,         32'd32,        1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  32'd0,         1'b1, 5'd0, 5'd0,  5'd3,  32'd0,         32'd4,         1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  32'd0,         1'b1, 5'd3, 5'd3,  5'd3,  32'd4,         32'd4,         1'b1, 1'b1);
        tbl[9]  = mk(1'b1, 5'd31, 32'hCAFEF00D,  1'b1, 5'd30, 32'h12345678,  1'b0, 5'd0, 5'd31, 5'd30, 32'hCAFEF00D,  32'h12345678,  1'b0, 1'b0);
        tbl[10] = mk(1'b1, 5'd3,  32'h77,        1'b1, 5'd3,  32'h88,        1'b0, 5'd0, 5'd3,  5'd31, 32'h88,        32'hCAFEF00D,  1'b0, 1'b0);
        tbl[11] = mk(1'b0, 5'd0,  32'd0,         1'b1, 5'd5,  32'hAAAA5555,  1'b1, 5'd6, 5'd5,  5'd6,  32'hAAAA5555,  32'd0,         1'b0, 1'b1);

        idle();
        rn   = 10'd0;
        rn_s = 20'd0;
        reset = 1'b1;
        repeat (2) tick_model();

        // reset state
        idle();
        rn   = {5'd31, 5'd1};
        rn_s = {5'd15, 5'd9, 5'd3, 5'd1};
        @(negedge clock);
        chk("reset_rd0", rd[31:0], 32'd0);
        chk("reset_rd1", rd[63:32], 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sweep_busy", 32'(busy_s), 32'd0);
        check_model();
        tick_model();

        for (int v = 0; v < NV; v++) begin
            idle();
            write0 = tbl[v].w0; wn0 = tbl[v].n0; wd0 = tbl[v].d0;
            write1 = tbl[v].w1; wn1 = tbl[v].n1; wd1 = tbl[v].d1;
            rsv    = tbl[v].rs; rsvn = tbl[v].rsn;
            step();
            idle();
            rn = {tbl[v].a1, tbl[v].a0};
            @(negedge clock);
            chk($sformatf("vec%0d_rd0", v), rd[31:0], tbl[v].e0);
            chk($sformatf("vec%0d_rd1", v), rd[63:32], tbl[v].e1);
            chk($sformatf("vec%0d_busy0", v), 32'(busy[0]), 32'(tbl[v].b0));
            chk($sformatf("vec%0d_busy1", v), 32'(busy[1]), 32'(tbl[v].b1));
            check_model();
            tick_model();
        end

        // reset clear: writes and reserves presented with Reset are dropped
        idle();
        write0 = 1'b1; wn0 = 5'd5; wd0 = 32'hDEADBEEF;
        rsv = 1'b1; rsvn = 5'd6;
        step();
        idle();
        rn = {5'd6, 5'd5};
        @(negedge clock);
        chk("pre_reset_r5", rd[31:0], 32'hDEADBEEF);
        chk("pre_reset_busy_r6", 32'(busy[1]), 32'd1);
        check_model();
        tick_model();
        reset = 1'b1;
        write0 = 1'b1; wn0 = 5'd9; wd0 = 32'd1;
        rsv = 1'b1; rsvn = 5'd9;
        step();
        idle();
        rn = {5'd6, 5'd5};
        @(negedge clock);
        chk("post_reset_r5", rd[31:0], 32'd0);
        chk("post_reset_busy_r5", 32'(busy[0]), 32'd0);
        chk("post_reset_busy_r6", 32'(busy[1]), 32'd0);
        check_model();
        tick_model();
        rn = {5'd9, 5'd9};
        @(negedge clock);
        chk("post_reset_r9", rd[31:0], 32'd0);
        chk("post_reset_busy_r9", 32'(busy[0]), 32'd0);
        tick_model();

        // same-cycle read of a register being written
        idle();
        write0 = 1'b1; wn0 = 5'd4; wd0 = 32'hA5;
        rn = {5'd4, 5'd4};
        @(negedge clock);
        chk("bypass_same_cycle", rd[31:0], BYP ? 32'hA5 : 32'd0);
        check_model();
        tick_model();
        idle();
        @(negedge clock);
        chk("bypass_next_cycle", rd[31:0], 32'hA5);
        tick_model();
        write0 = 1'b1; wn0 = 5'd4; wd0 = 32'd1;
        write1 = 1'b1; wn1 = 5'd4; wd1 = 32'd2;
        rsv = 1'b1; rsvn = 5'd4;
        @(negedge clock);
        chk("bypass_double_match", rd[31:0], BYP ? 32'd2 : 32'hA5);
        chk("bypass_busy_with_rsv", 32'(busy[0]), 32'd0 | 32'(BYP));
        check_model();
        tick_model();
        idle();
        @(negedge clock);
        chk("double_write_r4", rd[63:32], 32'd2);
        chk("double_write_busy_r4", 32'(busy[1]), 32'd1);
        tick_model();

        // sweep instance: r15 on all ports, r20 out of range
        idle();
        write0 = 1'b1; wn0 = 5'd15; wd0 = 32'h1234BEEF;
        step();
        idle();
        rn_s = {5'd15, 5'd15, 5'd15, 5'd15};
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sweep_r15_port%0d", i), 32'(rd_s[i*16 +: 16]), 32'h0000BEEF);
        end
        tick_model();
        write1 = 1'b1; wn1 = 5'd20; wd1 = 32'h1234;
        rsv = 1'b1; rsvn = 5'd20;
        step();
        idle();
        rn_s = {5'd20, 5'd20, 5'd20, 5'd20};
        @(negedge clock);
        chk("sweep_r20_rd", 32'(rd_s[15:0]), 32'd0);
        chk("sweep_r20_busy", 32'(busy_s), 32'd0);
        check_model();
        tick_model();

        // randomized traffic against the model
        repeat (600) begin
            reset  = ($urandom_range(0, 63) == 0);
            write0 = 1'($urandom_range(0, 1));
            wn0    = 5'($urandom_range(0, 31));
            wd0    = $urandom;
            write1 = 1'($urandom_range(0, 1));
            wn1    = ($urandom_range(0, 3) == 0) ? wn0 : 5'($urandom_range(0, 31));
            wd1    = $urandom;
            rsv    = ($urandom_range(0, 2) == 0);
            rsvn   = ($urandom_range(0, 3) == 0) ? wn1 : 5'($urandom_range(0, 31));
            for (int i = 0; i < 2; i++) rn[i*5 +: 5] = pick();
            for (int i = 0; i < 4; i++) rn_s[i*5 +: 5] = pick();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
